// File: rtl/qsys_seg7_scan.sv
// Avalon-MM slave that drives a multiplexed 7-segment display of up to 8 digits.
// It provides hex decode, digit scanning, decimal points, blanking and a ghost-guard gap cycle.
module qsys_seg7_scan #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] dig
);

  localparam int PCW  = $clog2(CLK_DIV);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PCW-1:0]  PC_LAST  = PCW'(CLK_DIV - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITS - 1);
  localparam logic [31:0] DATA_MASK = (DIGITS >= 8) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << (4 * DIGITS)) - 32'd1);
  localparam logic [31:0] DIG_MASK  = (32'd1 << DIGITS) - 32'd1;

  // Registers are kept 32 bits wide but masked on write, so bits beyond DIGITS stay zero.
  logic [31:0]     data_r;
  logic [31:0]     dp_r;
  logic [31:0]     blank_r;
  logic            en;
  logic            lzb;
  logic [PCW-1:0]  pc;
  logic [IDXW-1:0] idx;
  logic            wr;

  assign wr = chipselect && !write_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_r  <= '0;
      dp_r    <= '0;
      blank_r <= '0;
      en      <= 1'b0;
      lzb     <= 1'b0;
    end else if (wr) begin
      case (address)
        2'd0: data_r  <= writedata & DATA_MASK;
        2'd1: dp_r    <= writedata & DIG_MASK;
        2'd2: begin
          en  <= writedata[0];
          lzb <= writedata[1];
        end
        default: blank_r <= writedata & DIG_MASK;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = data_r;
      2'd1:    readdata = dp_r;
      2'd2:    readdata = {30'b0, lzb, en};
      default: readdata = blank_r;
    endcase
  end

  // With EN low the scan is parked at digit 0, slot start, so re-enabling begins with a gap.
  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      pc  <= '0;
      idx <= '0;
    end else if (pc == PC_LAST) begin
      pc  <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pc <= pc + 1'b1;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // upper_zero[i] is set when nibbles i..DIGITS-1 are all zero.
  logic [DIGITS-1:0] upper_zero;
  logic              zacc;

  always_comb begin
    upper_zero = '0;
    zacc       = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zacc          = zacc && (data_r[4*i +: 4] == 4'h0);
      upper_zero[i] = zacc;
    end
  end

  logic [3:0]        nib;
  logic [6:0]        seg_lit;
  logic              dp_lit;
  logic [DIGITS-1:0] dig_lit;

  assign nib = data_r[{idx, 2'b00} +: 4];

  always_comb begin
    seg_lit = '0;
    dp_lit  = 1'b0;
    dig_lit = '0;
    if (en && pc != '0) begin
      dig_lit[idx] = 1'b1;
      if (blank_r[idx]) begin
        seg_lit = '0;
      end else if (lzb && idx != '0 && upper_zero[idx]) begin
        dp_lit = dp_r[idx];
      end else begin
        seg_lit = hex7(nib);
        dp_lit  = dp_r[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg <= {7{SEG_ACTIVE_LOW}};
      dp  <= SEG_ACTIVE_LOW;
      dig <= {DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      seg <= seg_lit ^ {7{SEG_ACTIVE_LOW}};
      dp  <= dp_lit ^ SEG_ACTIVE_LOW;
      dig <= dig_lit ^ {DIGITS{DIG_ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_qsys_seg7_scan.sv
// Self-checking bench for qsys_seg7_scan: constant vectors, hand sequences and a random run.
// The random run is checked against a model that derives the pins from the time since enable.
module tb_qsys_seg7_scan;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig;

  qsys_seg7_scan #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .seg(seg), .dp(dp), .dig(dig)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: register image plus edges elapsed since the scan was enabled.
  logic [6:0]  glyph [16];
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0, m_blank = '0;
  logic        m_en = 1'b0, m_lzb = 1'b0;
  int          m_s = 0;

  task automatic model_out(output logic [6:0] s, output logic d, output logic [3:0] g,
                           output bit gap);
    int p, dd;
    logic [6:0] lit;
    logic       dlit;
    s = 7'h7F; d = 1'b1; g = 4'hF; gap = 1'b0;
    if (m_en) begin
      p  = (m_s - 1) % CLK_DIV;
      dd = ((m_s - 1) / CLK_DIV) % DIGITS;
      if (p == 0) begin
        gap = 1'b1;
      end else begin
        g = 4'hF;
        g[dd] = 1'b0;
        lit = glyph[m_data[4*dd +: 4]];
        dlit = m_dp[dd];
        if (m_blank[dd]) begin
          lit = 7'h00; dlit = 1'b0;
        end else if (m_lzb && dd != 0 && (m_data >> (4 * dd)) == 16'h0) begin
          lit = 7'h00;
        end
        s = ~lit;
        d = ~dlit;
      end
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {16'h0, m_data};
      2'd1:    return {28'h0, m_dp};
      2'd2:    return {30'h0, m_lzb, m_en};
      default: return {28'h0, m_blank};
    endcase
  endfunction

  // One clock: drive inputs on the falling edge, update the model at the rising edge, compare after it.
  task automatic cycle(input bit rst, input bit wr, input logic [1:0] a, input logic [31:0] wd);
    logic [6:0] es;
    logic       ed;
    logic [3:0] eg;
    bit         gap;
    @(negedge clk);
    reset_n = !rst; chipselect = wr; write_n = !wr; address = a; writedata = wd;
    @(posedge clk);
    if (rst) begin
      es = 7'h7F; ed = 1'b1; eg = 4'hF; gap = 1'b0;
      m_data = '0; m_dp = '0; m_blank = '0; m_en = 1'b0; m_lzb = 1'b0; m_s = 0;
    end else begin
      if (m_en) m_s++;
      model_out(es, ed, eg, gap);
      if (wr) begin
        case (a)
          2'd0: m_data = wd[15:0];
          2'd1: m_dp = wd[3:0];
          2'd2: begin
            if (wd[0] && !m_en) m_s = 0;
            m_en = wd[0]; m_lzb = wd[1];
          end
          default: m_blank = wd[3:0];
        endcase
      end
    end
    #1;
    check("model dig", {28'h0, dig}, {28'h0, eg});
    if (!gap) begin
      check("model seg", {25'h0, seg}, {25'h0, es});
      check("model dp", {31'h0, dp}, {31'h0, ed});
    end
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
    cycle(1'b0, 1'b1, a, wd);
  endtask

  task automatic check_read(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic wait_dig(input int d, output bit ok);
    logic [3:0] sel;
    sel = 4'hF;
    sel[d] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      idle();
      if (dig === sel) ok = 1'b1;
    end
    if (!ok) begin
      fails++;
      tests++;
      $display("FAIL wait_dig timeout: dig %h never reached %h", dig, sel);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic [1:0]  ctrl;
    logic [3:0]  dpm;
    logic [3:0]  blank;
    int          digit;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit ok;
    logic [6:0]  frame_seg [4];
    logic [3:0]  exp_g;
    logic [31:0] lz_masks [4];
    logic [31:0] wd;
    logic [1:0]  a;

    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    frame_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    lz_masks  = '{32'h0000_FFFF, 32'h0000_0FFF, 32'h0000_00FF, 32'h0000_000F};

    vecs.push_back('{16'h1234, 2'd1, 4'h0, 4'h0, 0, 7'h19, 1'b1});
    vecs.push_back('{16'h1234, 2'd1, 4'h0, 4'h0, 1, 7'h30, 1'b1});
    vecs.push_back('{16'h1234, 2'd1, 4'h0, 4'h0, 2, 7'h24, 1'b1});
    vecs.push_back('{16'h1234, 2'd1, 4'h0, 4'h0, 3, 7'h79, 1'b1});
    vecs.push_back('{16'h0007, 2'd3, 4'h0, 4'h0, 1, 7'h7F, 1'b1});
    vecs.push_back('{16'h0007, 2'd3, 4'h0, 4'h0, 3, 7'h7F, 1'b1});
    vecs.push_back('{16'h0007, 2'd3, 4'h0, 4'h0, 0, 7'h78, 1'b1});
    vecs.push_back('{16'h0000, 2'd3, 4'h0, 4'h0, 0, 7'h40, 1'b1});
    vecs.push_back('{16'h0500, 2'd3, 4'h0, 4'h0, 1, 7'h40, 1'b1});
    vecs.push_back('{16'h0500, 2'd3, 4'h0, 4'h0, 2, 7'h12, 1'b1});
    vecs.push_back('{16'h0500, 2'd3, 4'h2, 4'h0, 3, 7'h7F, 1'b1});
    vecs.push_back('{16'h1234, 2'd1, 4'h5, 4'h4, 0, 7'h19, 1'b0});
    vecs.push_back('{16'h1234, 2'd1, 4'h5, 4'h4, 1, 7'h30, 1'b1});
    vecs.push_back('{16'h1234, 2'd1, 4'h5, 4'h4, 2, 7'h7F, 1'b1});
    vecs.push_back('{16'h1234, 2'd1, 4'h5, 4'h4, 3, 7'h79, 1'b1});
    vecs.push_back('{16'hABCD, 2'd3, 4'h8, 4'h0, 3, 7'h08, 1'b0});
    vecs.push_back('{16'hABCD, 2'd3, 4'h0, 4'h0, 1, 7'h46, 1'b1});

    // Reset and idle readback
    cycle(1'b1, 1'b0, 2'd0, 32'h0);
    cycle(1'b1, 1'b0, 2'd0, 32'h0);
    check("reset seg", {25'h0, seg}, 32'h7F);
    check("reset dp", {31'h0, dp}, 32'h1);
    check("reset dig", {28'h0, dig}, 32'hF);
    for (int i = 0; i < 4; i++) check_read("reset read", 2'(i), 32'h0);

    // Full frame after enabling with DATA=0x1234
    wr_reg(2'd0, 32'h0000_1234);
    wr_reg(2'd2, 32'h1);
    for (int i = 0; i < 32; i++) begin
      idle();
      exp_g = 4'hF;
      if (i % 4 != 0) exp_g[(i / 4) % 4] = 1'b0;
      check("frame dig", {28'h0, dig}, {28'h0, exp_g});
      if (i % 4 != 0) check("frame seg", {25'h0, seg}, {25'h0, frame_seg[(i / 4) % 4]});
    end

    // Constant vector table
    foreach (vecs[i]) begin
      wr_reg(2'd0, {16'h0, vecs[i].data});
      wr_reg(2'd1, {28'h0, vecs[i].dpm});
      wr_reg(2'd3, {28'h0, vecs[i].blank});
      wr_reg(2'd2, {30'h0, vecs[i].ctrl});
      wait_dig(vecs[i].digit, ok);
      if (ok) begin
        check("vec seg", {25'h0, seg}, {25'h0, vecs[i].seg});
        check("vec dp", {31'h0, dp}, {31'h0, vecs[i].dp});
      end
    end

    // Clear EN while digit 2 is lit, then re-enable
    wr_reg(2'd1, 32'h0);
    wr_reg(2'd3, 32'h0);
    wait_dig(2, ok);
    wr_reg(2'd2, 32'h0);
    idle();
    check("disable dig", {28'h0, dig}, 32'hF);
    check("disable seg", {25'h0, seg}, 32'h7F);
    check("disable dp", {31'h0, dp}, 32'h1);
    idle();
    wr_reg(2'd2, 32'h1);
    idle();
    check("reenable gap", {28'h0, dig}, 32'hF);
    idle();
    check("reenable digit0", {28'h0, dig}, 32'hE);

    // Reset pulse mid-frame
    idle();
    cycle(1'b1, 1'b0, 2'd0, 32'h0);
    check("midreset seg", {25'h0, seg}, 32'h7F);
    check("midreset dp", {31'h0, dp}, 32'h1);
    check("midreset dig", {28'h0, dig}, 32'hF);
    for (int i = 0; i < 4; i++) check_read("midreset read", 2'(i), 32'h0);
    idle();
    idle();
    check("midreset stays dark", {28'h0, dig}, 32'hF);

    // All-ones readback
    for (int i = 0; i < 4; i++) wr_reg(2'(i), 32'hFFFF_FFFF);
    check_read("ones data", 2'd0, 32'h0000_FFFF);
    check_read("ones dp", 2'd1, 32'h0000_000F);
    check_read("ones ctrl", 2'd2, 32'h0000_0003);
    check_read("ones blank", 2'd3, 32'h0000_000F);

    // Randomized run against the model
    wr_reg(2'd3, 32'h0);
    for (int it = 0; it < 60; it++) begin
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (a == 2'd0) wd = wd & lz_masks[$urandom_range(0, 3)];
      if (a == 2'd2 && $urandom_range(0, 4) != 0) wd[0] = 1'b1;
      if (a == 2'd3 && $urandom_range(0, 2) != 0) wd = 32'h0;
      wr_reg(a, wd);
      check_read("random read", a, model_read(a));
      repeat ($urandom_range(1, 20)) idle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qsys_seg7_scan.md
# qsys_seg7_scan

Parametrised Avalon-MM slave that drives a multiplexed common-anode/common-cathode 7-segment display of up to 8 digits. It replaces a plain 16-bit PIO output with on-chip hex decode, digit scanning, per-digit decimal points, blank masks, leading-zero blanking and a ghosting guard. It sits on the Qsys Avalon bus next to the other PIO peripherals, and its outputs go straight to board pins.

## Interface
Parameters:
- DIGITS, 4: number of digits. Legal range is 1..8.
- CLK_DIV, 50000: clock cycles per digit slot. Must be >= 2.
- SEG_ACTIVE_LOW, 1: when 1, `seg` and `dp` drive 0 to light.
- DIG_ACTIVE_LOW, 1: when 1, `dig` drives 0 to select a digit.

Ports:
- clk  in  1  system clock. Single clock domain.
- reset_n  in  1  reset. Synchronous, active-low.
- address  in  2  register word address.
- chipselect  in  1  Avalon chip select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data. Combinational from `address`; zero wait states.
- seg  out  7  segment drive; bit0=a … bit6=g. Registered.
- dp  out  1  decimal point drive. Registered.
- dig  out  DIGITS  one-hot digit select. Registered.

## Operation
Register map (write when `chipselect && !write_n`; unused bits read 0; unused writedata bits are ignored):
- 0 DATA: [4*DIGITS-1:0], one hex nibble per digit. Digit 0 is at bits [3:0].
- 1 DP: [DIGITS-1:0], decimal point enable per digit.
- 2 CTRL: bit0 EN (scan enable); bit1 LZB (leading-zero blanking).
- 3 BLANK: [DIGITS-1:0], force digit dark.
- All registers reset to 0. Address 2 reads back {30'b0, LZB, EN}.

Scan engine:
- Prescaler `pc` counts 0..CLK_DIV-1. Digit index `idx` counts 0..DIGITS-1.
- When `pc` reaches CLK_DIV-1, `pc` wraps to 0 and `idx` increments. `idx` wraps from DIGITS-1 to 0.
- State GAP (`pc`==0): `dig` is all inactive. This is the ghosting guard.
- State ON (`pc`>=1): `dig` has the bit `idx` active.
- EN=0: `pc` and `idx` are held at 0, and `seg`, `dp` and `dig` are all inactive.
- Clearing EN mid-slot takes effect on the next output register update. Setting EN restarts the scan at digit 0 in GAP.

Digit content for the current `idx`:
- BLANK[idx]=1: `seg` and `dp` are inactive.
- Otherwise, when LZB=1 and idx!=0 and every nibble from `idx` up to DIGITS-1 is zero: `seg` is inactive and `dp` follows DP[idx].
- Otherwise: `seg` is the hex decode of the nibble (0-F using standard glyphs; b, d are lowercase) and `dp` = DP[idx].
- Digit 0 is never blanked by LZB.
- Polarity is applied last, after all of the rules above.

Reset and inactive levels:
- Reset values: `seg` = all inactive (7'h7F when active-low), `dp` inactive, `dig` all inactive.
- Reset asserted mid-scan: on the next clk edge `pc` and `idx` return to 0, all registers clear, and all outputs go inactive.

## Timing
- Outputs are registered from the current `pc`, `idx` and register contents. A register write at edge N becomes visible on the pins at edge N+1 (if that cycle is ON).
- Each slot lasts CLK_DIV cycles: 1 GAP cycle, then CLK_DIV-1 ON cycles. A frame lasts DIGITS*CLK_DIV cycles.
- After EN is written to 1 at edge N, the first GAP output appears at edge N+1. Digit 0 is first lit at edge N+2.
- Writing DATA during a slot updates the glyph mid-slot. No tearing protection is provided.
- `readdata` is valid in the same cycle as `address`.

## Test plan
Bench parameters: DIGITS=4, CLK_DIV=4, both polarities = 1.
- Reset: hold reset_n=0 for 2 clk -> `seg`=7'h7F, `dp`=1, `dig`=4'hF; readdata=0 at addresses 0..3.
- Write DATA=0x1234, then CTRL=1 -> the pins repeat this pattern:
  - 1 cycle with `dig`=F;
  - 3 cycles with `dig`=E, `seg`=7'h19 ('4');
  - then `dig`=D shows '3' (7'h30), `dig`=B shows '2' (7'h24), `dig`=7 shows '1' (7'h79);
  - the frame repeats every 16 cycles.
- LZB checks with CTRL=3:
  - DATA=0x0007 -> digits 1-3 show `seg`=7'h7F with `dig` still active; digit 0 shows `seg`=7'h78.
  - DATA=0 -> digit 0 shows 7'h40.
  - DATA=0x0500 -> digit 1 shows 7'h40 (not blanked, because nibble 2 is non-zero).
- Masks: DP=4'b0101 and BLANK=4'b0100 -> digit 0 has `dp`=0; digit 2 has `seg`=7'h7F and `dp`=1; the other digits have `dp`=1.
- Enable and reset mid-scan:
  - Write CTRL=0 while digit 2 is lit -> all outputs go inactive at the next edge.
  - Write CTRL=1 -> GAP, then digit 0 is lit.
  - Pulse reset_n=0 for 1 cycle mid-frame -> outputs inactive and all registers read 0.
- Register readback: write 0xFFFFFFFF to addresses 0..3 -> reads return 0x0000FFFF, 0xF, 0x3 and 0xF.
